cache_arbiter: RTL
==================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- icache_read  in  1  I-cache line-fill request.
- icache_address  in  16 (lc3b_word)  I-cache line address.
- icache_rdata  out  128 (lc3b_cline)  fill data to I-cache.
- icache_resp  out  1  I-cache transaction complete.
- dcache_read  in  1  D-cache line-fill request.
- dcache_write  in  1  D-cache writeback request.
- dcache_address  in  16  D-cache line address.
- dcache_wdata  in  128  writeback data.
- dcache_rdata  out  128  fill data to D-cache.
- dcache_resp  out  1  D-cache transaction complete.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  16  memory address.
- mem_wdata  out  128  memory write data.
- mem_rdata  in  128  memory read data.
- mem_resp  in  1  memory transaction complete.
- i_grant_count  out  16  I-side grants since reset.
- d_grant_count  out  16  D-side grants since reset.
REQ-002 Parameters, one per line: name, default, meaning: none; all widths come from package types.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, SERVE_I, SERVE_D.
REQ-004 In IDLE: if a D request (dcache_read or dcache_write) is pending, the next state SHALL be SERVE_D; otherwise, if icache_read is pending, SERVE_I; otherwise IDLE.
REQ-005 In SERVE_x, the FSM SHALL stay until mem_resp=1, then return to IDLE on the next edge.
REQ-006 In SERVE_I, the block SHALL drive mem_read=1, mem_write=0, mem_address=icache_address.
REQ-007 In SERVE_D, the block SHALL drive mem_read=dcache_read&!dcache_write, mem_write=dcache_write, mem_address=dcache_address, mem_wdata=dcache_wdata; write wins if both strobes are set.
REQ-008 In IDLE, mem_read and mem_write SHALL be 0.
REQ-009 icache_resp SHALL equal mem_resp in SERVE_I, and dcache_resp SHALL equal mem_resp in SERVE_D; both SHALL be 0 elsewhere (combinational, one-cycle pulse).
REQ-010 icache_rdata and dcache_rdata SHALL both be driven from mem_rdata continuously.
REQ-011 Latency: a request first seen in IDLE at edge N SHALL produce a memory strobe in cycle N+1. The minimum gap between consecutive transactions is one IDLE cycle.
REQ-012 A request deasserted mid-transaction SHALL NOT abort it; the FSM holds SERVE_x and the strobe type latched at grant until mem_resp.
REQ-013 A mem_resp in IDLE SHALL be ignored.
REQ-014 The grant counters SHALL increment by 1 on each IDLE->SERVE_I or IDLE->SERVE_D transition, respectively, and wrap 0xFFFF->0x0000.

Reset
REQ-015 When rst_n=0, asynchronously: state SHALL be IDLE; all strobes and resps SHALL be 0; both counters SHALL be 0; any in-flight transaction SHALL be abandoned.
REQ-016 After rst_n rises, the first grant SHALL occur no earlier than the first clk edge.

Configuration
REQ-017 Macro ARB_ROUND_ROBIN_EN:
- When defined: a last_grant flop (reset value I) is kept. When both sides are pending in IDLE, the side not granted last SHALL win.
- When undefined: fixed D priority per REQ-004; no last_grant flop.

Structure
REQ-018 The lc3b_types package SHALL hold lc3b_word, lc3b_cline (128-bit) and the arbiter state enum.
REQ-019 Grant counters SHALL be one reused sub-module, grant_counter (16-bit, enable, async active-low clear), instantiated twice.

Verification
REQ-020 The bench SHALL cover these scenarios:
- icache_read=1, addr 0x1230, mem_resp after 3 cycles -> mem_read=1 with mem_address=0x1230 for 3 cycles; icache_resp pulses once; i_grant_count=1.
- I and D read together, no macro -> D served first, then I; d_grant_count=1, i_grant_count=1.
- Same as above with ARB_ROUND_ROBIN_EN and a prior D grant -> I served first.
- dcache_write, addr 0x4000, wdata 0xA5..A5 -> mem_write=1 with matching address and data; mem_read=0; dcache_resp pulses once.
- rst_n=0 mid-SERVE_D -> strobes 0 immediately; state IDLE; counters 0.
- 65536 I grants -> i_grant_count wraps to 0x0000.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared widths, bus types and arbiter state encoding for the LC-3b cache/memory path.
package lc3b_types;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned LINE_W = 128;
   localparam int unsigned CNT_W  = 16;

   typedef logic [ADDR_W-1:0] lc3b_word;
   typedef logic [LINE_W-1:0] lc3b_cline;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SERVE_I = 2'd1,
      S_SERVE_D = 2'd2
   } arb_state_e;

   // Which cache won the most recent grant (used by round-robin arbitration).
   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_side_e;

endpackage

// File: rtl/grant_counter.sv
// Free-running grant counter: increments on en_i, wraps at full scale, async active-low clear.
module grant_counter
   import lc3b_types::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: natural modulo-2^CNT_W wrap on overflow.
   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache line fills and D-cache fills/writebacks onto one memory port.
// Optional build macro ARB_ROUND_ROBIN_EN: when both caches are pending in IDLE the
// side not granted last wins; otherwise the D-cache always has priority.
module cache_arbiter
   import lc3b_types::*;
(
   input  logic       clk,
   input  logic       rst_n,

   input  logic       icache_read,
   input  lc3b_word   icache_address,
   output lc3b_cline  icache_rdata,
   output logic       icache_resp,

   input  logic       dcache_read,
   input  logic       dcache_write,
   input  lc3b_word   dcache_address,
   input  lc3b_cline  dcache_wdata,
   output lc3b_cline  dcache_rdata,
   output logic       dcache_resp,

   output logic       mem_read,
   output logic       mem_write,
   output lc3b_word   mem_address,
   output lc3b_cline  mem_wdata,
   input  lc3b_cline  mem_rdata,
   input  logic       mem_resp,

   output logic [CNT_W-1:0] i_grant_count,
   output logic [CNT_W-1:0] d_grant_count
);

   arb_state_e state_q, state_d;
   // Strobe type captured at grant so a dropped request cannot change it mid-transfer.
   logic       rd_q, rd_d;
   logic       wr_q, wr_d;
   logic       i_grant, d_grant;
   logic       d_pending;
   logic       pick_d;

`ifdef ARB_ROUND_ROBIN_EN
   grant_side_e last_q, last_d;
`endif

   // Next-state, grant selection and memory-side strobes.
   always_comb begin
      state_d     = state_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      i_grant     = 1'b0;
      d_grant     = 1'b0;
      d_pending   = dcache_read | dcache_write;
      pick_d      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = lc3b_word'(0);
      icache_resp = 1'b0;
      dcache_resp = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d      = last_q;
`endif

      case (state_q)
         S_IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_d = d_pending & ~(icache_read & (last_q == GRANT_D));
`else
            pick_d = d_pending;
`endif
            if (pick_d) begin
               state_d = S_SERVE_D;
               wr_d    = dcache_write;
               rd_d    = dcache_read & ~dcache_write;
               d_grant = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
               last_d  = GRANT_D;
`endif
            end else if (icache_read) begin
               state_d = S_SERVE_I;
               i_grant = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
               last_d  = GRANT_I;
`endif
            end
         end

         S_SERVE_I: begin
            mem_read    = 1'b1;
            mem_address = icache_address;
            icache_resp = mem_resp;
            if (mem_resp) begin
               state_d = S_IDLE;
            end
         end

         S_SERVE_D: begin
            mem_read    = rd_q;
            mem_write   = wr_q;
            mem_address = dcache_address;
            dcache_resp = mem_resp;
            if (mem_resp) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latched strobe-type registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Remembers the last granted side; starts as I so D wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= GRANT_I;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   // Fill data fans out to both caches; writeback data passes straight through.
   assign icache_rdata = mem_rdata;
   assign dcache_rdata = mem_rdata;
   assign mem_wdata    = dcache_wdata;

   grant_counter u_i_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (i_grant),
      .count_o (i_grant_count)
   );

   grant_counter u_d_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (d_grant),
      .count_o (d_grant_count)
   );

endmodule
